// File: rtl/gpio_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_scan_ctrl
// Description : Serial-scan front end for the GPIO-mode SRAM test path.
//               A 112-bit command packet is shifted in MSB-first, decoded
//               into dual-port SRAM controls plus a one-hot macro select,
//               one access is issued per global_csb low strobe, and read
//               data can be reloaded into the packet to shift back out.
//               Optional macro GPIO_SCAN_PKT_CHECK_EN: flags and suppresses
//               accesses issued from a short (incomplete) packet.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_scan_ctrl #(
    parameter int SEL_W     = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int WMASK_W   = 4,
    parameter int NUM_SRAMS = 16
) (
    input  logic                 gpio_clk,
    input  logic                 gpio_resetn,
    input  logic                 gpio_in,
    input  logic                 gpio_scan,
    input  logic                 gpio_sram_load,
    input  logic                 global_csb,
    output logic                 gpio_out,
    output logic [NUM_SRAMS-1:0] sram_sel,
    output logic                 sram_csb0,
    output logic                 sram_web0,
    output logic [WMASK_W-1:0]   sram_wmask0,
    output logic [ADDR_W-1:0]    sram_addr0,
    output logic [DATA_W-1:0]    sram_din0,
    input  logic [DATA_W-1:0]    sram_dout0,
    output logic                 sram_csb1,
    output logic                 sram_web1,
    output logic [WMASK_W-1:0]   sram_wmask1,
    output logic [ADDR_W-1:0]    sram_addr1,
    output logic [DATA_W-1:0]    sram_din1,
    input  logic [DATA_W-1:0]    sram_dout1,
    output logic                 packet_err
);

    // Packet geometry: one port field is {addr, din, csb, web, wmask}
    localparam int PORT_W    = ADDR_W + DATA_W + 2 + WMASK_W;
    localparam int PKT_W     = SEL_W + 2 * PORT_W;
    localparam int WM1_LSB   = 0;
    localparam int WEB1_BIT  = WMASK_W;
    localparam int CSB1_BIT  = WMASK_W + 1;
    localparam int DIN1_LSB  = WMASK_W + 2;
    localparam int ADDR1_LSB = DIN1_LSB + DATA_W;
    localparam int WM0_LSB   = PORT_W + WM1_LSB;
    localparam int WEB0_BIT  = PORT_W + WEB1_BIT;
    localparam int CSB0_BIT  = PORT_W + CSB1_BIT;
    localparam int DIN0_LSB  = PORT_W + DIN1_LSB;
    localparam int ADDR0_LSB = PORT_W + ADDR1_LSB;
    localparam int SEL_LSB   = 2 * PORT_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [PKT_W-1:0]       pkt_q;
    logic [PKT_W-1:0]       pkt_d;
    logic [DATA_W-1:0]      dout0_q;
    logic [DATA_W-1:0]      dout1_q;
    logic [NUM_SRAMS-1:0]   sram_sel_q;
    logic                   sram_csb0_q;
    logic                   sram_web0_q;
    logic [WMASK_W-1:0]     sram_wmask0_q;
    logic [ADDR_W-1:0]      sram_addr0_q;
    logic [DATA_W-1:0]      sram_din0_q;
    logic                   sram_csb1_q;
    logic                   sram_web1_q;
    logic [WMASK_W-1:0]     sram_wmask1_q;
    logic [ADDR_W-1:0]      sram_addr1_q;
    logic [DATA_W-1:0]      sram_din1_q;
    logic [NUM_SRAMS-1:0]   sel_onehot;
    logic                   start_access;
    logic                   suppress;

    // A strobe is only honoured when armed and the scan chain is quiet
    assign start_access = (state_q == S_ARMED) && !global_csb && !gpio_scan;
    assign sel_onehot   = NUM_SRAMS'(1) << pkt_q[SEL_LSB +: SEL_W];

`ifdef GPIO_SCAN_PKT_CHECK_EN
    localparam int                CNT_W   = $clog2(PKT_W + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(PKT_W);

    logic [CNT_W-1:0] bit_cnt_q;
    logic             packet_err_q;

    // An access launched before a full packet has been shifted is blocked
    assign suppress   = (bit_cnt_q != CNT_MAX);
    assign packet_err = packet_err_q;

    // Saturating count of bits shifted since the last access or load
    always_ff @(posedge gpio_clk) begin
        if (!gpio_resetn) begin
            bit_cnt_q <= '0;
        end else if (gpio_scan) begin
            if (bit_cnt_q != CNT_MAX) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
        end else if (gpio_sram_load || start_access) begin
            bit_cnt_q <= '0;
        end
    end

    // Sticky short-packet flag, cleared only by reset
    always_ff @(posedge gpio_clk) begin
        if (!gpio_resetn) begin
            packet_err_q <= 1'b0;
        end else if (start_access && suppress) begin
            packet_err_q <= 1'b1;
        end
    end
`else
    assign suppress   = 1'b0;
    assign packet_err = 1'b0;
`endif

    // Next packet value: shifting has priority over reloading read data
    always_comb begin
        pkt_d = pkt_q;
        if (gpio_scan) begin
            pkt_d = {pkt_q[PKT_W-2:0], gpio_in};
        end else if (gpio_sram_load) begin
            pkt_d[DIN0_LSB +: DATA_W] = dout0_q;
            pkt_d[DIN1_LSB +: DATA_W] = dout1_q;
        end
    end

    // Packet shift/load register
    always_ff @(posedge gpio_clk) begin
        if (!gpio_resetn) begin
            pkt_q <= '0;
        end else begin
            pkt_q <= pkt_d;
        end
    end

    // Access sequencer with registered SRAM-side outputs
    always_ff @(posedge gpio_clk) begin
        if (!gpio_resetn) begin
            state_q       <= S_IDLE;
            sram_sel_q    <= '0;
            sram_csb0_q   <= 1'b1;
            sram_web0_q   <= 1'b1;
            sram_wmask0_q <= '0;
            sram_addr0_q  <= '0;
            sram_din0_q   <= '0;
            sram_csb1_q   <= 1'b1;
            sram_web1_q   <= 1'b1;
            sram_wmask1_q <= '0;
            sram_addr1_q  <= '0;
            sram_din1_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Out of reset the strobe must be seen high before arming
                    if (global_csb) begin
                        state_q <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (start_access) begin
                        state_q       <= S_ACCESS;
                        sram_sel_q    <= sel_onehot;
                        sram_csb0_q   <= pkt_q[CSB0_BIT] | suppress;
                        sram_web0_q   <= pkt_q[WEB0_BIT];
                        sram_wmask0_q <= pkt_q[WM0_LSB +: WMASK_W];
                        sram_addr0_q  <= pkt_q[ADDR0_LSB +: ADDR_W];
                        sram_din0_q   <= pkt_q[DIN0_LSB +: DATA_W];
                        sram_csb1_q   <= pkt_q[CSB1_BIT] | suppress;
                        sram_web1_q   <= pkt_q[WEB1_BIT];
                        sram_wmask1_q <= pkt_q[WM1_LSB +: WMASK_W];
                        sram_addr1_q  <= pkt_q[ADDR1_LSB +: ADDR_W];
                        sram_din1_q   <= pkt_q[DIN1_LSB +: DATA_W];
                    end
                end
                S_ACCESS: begin
                    state_q     <= S_HOLD;
                    sram_csb0_q <= 1'b1;
                    sram_csb1_q <= 1'b1;
                end
                S_HOLD: begin
                    // A long strobe yields a single access; wait for release
                    if (global_csb) begin
                        state_q <= S_ARMED;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read-data capture on the edge that ends the access cycle
    always_ff @(posedge gpio_clk) begin
        if (!gpio_resetn) begin
            dout0_q <= '0;
            dout1_q <= '0;
        end else if (state_q == S_ACCESS) begin
            if (!sram_csb0_q && sram_web0_q) begin
                dout0_q <= sram_dout0;
            end
            if (!sram_csb1_q && sram_web1_q) begin
                dout1_q <= sram_dout1;
            end
        end
    end

    assign gpio_out    = pkt_q[PKT_W-1];
    assign sram_sel    = sram_sel_q;
    assign sram_csb0   = sram_csb0_q;
    assign sram_web0   = sram_web0_q;
    assign sram_wmask0 = sram_wmask0_q;
    assign sram_addr0  = sram_addr0_q;
    assign sram_din0   = sram_din0_q;
    assign sram_csb1   = sram_csb1_q;
    assign sram_web1   = sram_web1_q;
    assign sram_wmask1 = sram_wmask1_q;
    assign sram_addr1  = sram_addr1_q;
    assign sram_din1   = sram_din1_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_scan_ctrl
// Description : Directed self-checking bench for gpio_scan_ctrl. Expected
//               SRAM accesses and expected scan-out packets are queued when
//               stimulus is driven and compared when the DUT produces them.
//               Honours GPIO_SCAN_PKT_CHECK_EN when defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_scan_ctrl;

    localparam int PKT_W = 112;

    // Packet layout, MSB first
    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] addr0;
        logic [31:0] din0;
        logic        csb0;
        logic        web0;
        logic [3:0]  wmask0;
        logic [15:0] addr1;
        logic [31:0] din1;
        logic        csb1;
        logic        web1;
        logic [3:0]  wmask1;
    } pkt_t;

    logic        gpio_clk = 1'b0;
    logic        gpio_resetn;
    logic        gpio_in;
    logic        gpio_scan;
    logic        gpio_sram_load;
    logic        global_csb;
    logic        gpio_out;
    logic [15:0] sram_sel;
    logic        sram_csb0, sram_web0, sram_csb1, sram_web1;
    logic [3:0]  sram_wmask0, sram_wmask1;
    logic [15:0] sram_addr0, sram_addr1;
    logic [31:0] sram_din0, sram_din1, sram_dout0, sram_dout1;
    logic        packet_err;

    int checks = 0;
    int errors = 0;
    int acc_seen = 0;
    int unexpected = 0;
    logic [123:0] exp_acc_q [$];
    logic [111:0] exp_pkt_q [$];

    logic        model_init;
    logic [31:0] mem [0:15];

    always #5 gpio_clk = ~gpio_clk;

    gpio_scan_ctrl dut (
        .gpio_clk       (gpio_clk),
        .gpio_resetn    (gpio_resetn),
        .gpio_in        (gpio_in),
        .gpio_scan      (gpio_scan),
        .gpio_sram_load (gpio_sram_load),
        .global_csb     (global_csb),
        .gpio_out       (gpio_out),
        .sram_sel       (sram_sel),
        .sram_csb0      (sram_csb0),
        .sram_web0      (sram_web0),
        .sram_wmask0    (sram_wmask0),
        .sram_addr0     (sram_addr0),
        .sram_din0      (sram_din0),
        .sram_dout0     (sram_dout0),
        .sram_csb1      (sram_csb1),
        .sram_web1      (sram_web1),
        .sram_wmask1    (sram_wmask1),
        .sram_addr1     (sram_addr1),
        .sram_din1      (sram_din1),
        .sram_dout1     (sram_dout1),
        .packet_err     (packet_err)
    );

    // Simple SRAM model: read data follows the address, writes on the edge
    assign sram_dout0 = mem[sram_addr0[3:0]];
    assign sram_dout1 = mem[sram_addr1[3:0]];
    always @(posedge gpio_clk) begin
        if (model_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
            mem[2] <= 32'd24;
        end else begin
            if (!sram_csb0 && !sram_web0) mem[sram_addr0[3:0]] <= sram_din0;
            if (!sram_csb1 && !sram_web1) mem[sram_addr1[3:0]] <= sram_din1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [123:0] acc_of(input pkt_t p);
        logic [15:0] oh;
        oh = 16'h0001 << p.sel;
        return {oh, p.csb0, p.web0, p.wmask0, p.addr0, p.din0,
                p.csb1, p.web1, p.wmask1, p.addr1, p.din1};
    endfunction

    task automatic tick();
        @(negedge gpio_clk);
    endtask

    task automatic shift_in(input pkt_t p);
        logic [PKT_W-1:0] v;
        v = p;
        for (int i = PKT_W - 1; i >= 0; i--) begin
            gpio_scan = 1'b1;
            gpio_in   = v[i];
            tick();
        end
        gpio_scan = 1'b0;
        gpio_in   = 1'b0;
    endtask

    task automatic scan_out(output logic [PKT_W-1:0] v);
        for (int i = PKT_W - 1; i >= 0; i--) begin
            v[i]      = gpio_out;
            gpio_scan = 1'b1;
            gpio_in   = 1'b0;
            tick();
        end
        gpio_scan = 1'b0;
    endtask

    // Access monitor: every cycle with a chip select low is one access
    initial forever begin
        @(posedge gpio_clk);
        #1;
        if (!sram_csb0 || !sram_csb1) begin
            acc_seen++;
            if (exp_acc_q.size() == 0) begin
                unexpected++;
            end else begin
                chk("access", {sram_sel, sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
                               sram_csb1, sram_web1, sram_wmask1, sram_addr1, sram_din1},
                    exp_acc_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t             p;
        pkt_t             q;
        logic [PKT_W-1:0] got;
        int               n0;

        gpio_resetn = 1'b0; gpio_in = 1'b0; gpio_scan = 1'b0;
        gpio_sram_load = 1'b0; global_csb = 1'b1; model_init = 1'b1;
        tick(); tick();
        model_init  = 1'b0;
        gpio_resetn = 1'b1;
        tick();

        // Fill with ones, then reset for two cycles in the middle of shifting
        for (int i = 0; i < PKT_W + 4; i++) begin
            gpio_scan = 1'b1; gpio_in = 1'b1; tick();
        end
        chk("ones_msb", gpio_out, 1'b1);
        gpio_resetn = 1'b0;
        tick(); tick();
        chk("rst_gpio_out", gpio_out, 1'b0);
        chk("rst_csb0", sram_csb0, 1'b1);
        chk("rst_csb1", sram_csb1, 1'b1);
        chk("rst_web0", sram_web0, 1'b1);
        chk("rst_web1", sram_web1, 1'b1);
        chk("rst_sel", sram_sel, 16'h0000);
        chk("rst_addr0", sram_addr0, 16'h0000);
        chk("rst_err", packet_err, 1'b0);

        // Strobe already low out of reset must be ignored
        gpio_scan = 1'b0; gpio_in = 1'b0; global_csb = 1'b0;
        gpio_resetn = 1'b1;
        n0 = acc_seen;
        tick(); tick(); tick();
        chk("fresh_low_ignored", acc_seen - n0, 0);
        global_csb = 1'b1;
        tick();

        // Write: port 0 writes 3 to address 1 of macro 3
        p = '0;
        p.sel = 4'd3; p.addr0 = 16'd1; p.din0 = 32'd3; p.csb0 = 1'b0; p.web0 = 1'b0;
        p.wmask0 = 4'hF; p.csb1 = 1'b1; p.web1 = 1'b1;
        shift_in(p);
        exp_acc_q.push_back(acc_of(p));
        n0 = acc_seen;
        global_csb = 1'b0;
        tick();
        chk("wr_sel", sram_sel, 16'h0008);
        chk("wr_csb0", sram_csb0, 1'b0);
        chk("wr_web0", sram_web0, 1'b0);
        chk("wr_addr0", sram_addr0, 16'd1);
        chk("wr_din0", sram_din0, 32'd3);
        chk("wr_csb1", sram_csb1, 1'b1);
        global_csb = 1'b1;
        tick();
        chk("wr_csb0_release", sram_csb0, 1'b1);
        chk("wr_count", acc_seen - n0, 1);

        // Read back both ports, reload and scan out
        p = '0;
        p.sel = 4'd5; p.addr0 = 16'd1; p.csb0 = 1'b0; p.web0 = 1'b1;
        p.addr1 = 16'd2; p.csb1 = 1'b0; p.web1 = 1'b1;
        shift_in(p);
        exp_acc_q.push_back(acc_of(p));
        global_csb = 1'b0;
        tick();
        global_csb = 1'b1;
        tick();
        tick();
        gpio_sram_load = 1'b1;
        tick();
        gpio_sram_load = 1'b0;
        q = p; q.din0 = 32'd3; q.din1 = 32'd24;
        exp_pkt_q.push_back(q);
        scan_out(got);
        chk("rd_scan", got, exp_pkt_q.pop_front());

        // Strobe held low for five cycles gives one access
        p = '0;
        p.sel = 4'hA; p.addr0 = 16'd1; p.csb0 = 1'b0; p.web0 = 1'b1;
        p.addr1 = 16'd7; p.csb1 = 1'b1; p.web1 = 1'b1;
        shift_in(p);
        exp_acc_q.push_back(acc_of(p));
        n0 = acc_seen;
        global_csb = 1'b0;
        repeat (5) tick();
        global_csb = 1'b1;
        tick(); tick();
        chk("hold_one_access", acc_seen - n0, 1);

        // Load together with scan: shift wins, din fields keep shifted data
        p = '0;
        p.sel = 4'h6; p.addr0 = 16'h1234; p.din0 = 32'hDEADBEEF; p.csb0 = 1'b1; p.web0 = 1'b1;
        p.wmask0 = 4'h5; p.addr1 = 16'hBEEF; p.din1 = 32'h12345678; p.csb1 = 1'b1;
        p.web1 = 1'b0; p.wmask1 = 4'hA;
        gpio_sram_load = 1'b1;
        shift_in(p);
        gpio_sram_load = 1'b0;
        exp_pkt_q.push_back(p);
        scan_out(got);
        chk("load_scan_shift_wins", got, exp_pkt_q.pop_front());

        // Strobe while scanning is ignored (packet now all zero: csb fields low)
        n0 = acc_seen;
        global_csb = 1'b0; gpio_scan = 1'b1; gpio_in = 1'b0;
        repeat (4) tick();
        global_csb = 1'b1;
        tick();
        gpio_scan = 1'b0;
        tick();
        chk("scan_strobe_ignored", acc_seen - n0, 0);

        // Reset during the access cycle aborts it
        p = '0;
        p.sel = 4'd1; p.addr0 = 16'd3; p.csb0 = 1'b0; p.web0 = 1'b1;
        p.csb1 = 1'b1; p.web1 = 1'b1;
        shift_in(p);
        exp_acc_q.push_back(acc_of(p));
        global_csb = 1'b0;
        tick();
        gpio_resetn = 1'b0; global_csb = 1'b1;
        tick();
        chk("rst_abort_csb0", sram_csb0, 1'b1);
        chk("rst_abort_sel", sram_sel, 16'h0000);
        gpio_resetn = 1'b1;
        tick();

`ifdef GPIO_SCAN_PKT_CHECK_EN
        // Short packet: access suppressed, error latched
        n0 = acc_seen;
        for (int i = 0; i < 50; i++) begin
            gpio_scan = 1'b1; gpio_in = 1'b0; tick();
        end
        gpio_scan = 1'b0;
        global_csb = 1'b0;
        tick();
        chk("short_csb0", sram_csb0, 1'b1);
        chk("short_csb1", sram_csb1, 1'b1);
        global_csb = 1'b1;
        tick(); tick();
        chk("short_err", packet_err, 1'b1);
        chk("short_no_access", acc_seen - n0, 0);
        p = '0;
        p.sel = 4'd2; p.addr0 = 16'd5; p.csb0 = 1'b0; p.web0 = 1'b1;
        p.addr1 = 16'd2; p.csb1 = 1'b0; p.web1 = 1'b1;
        shift_in(p);
        exp_acc_q.push_back(acc_of(p));
        n0 = acc_seen;
        global_csb = 1'b0;
        tick();
        global_csb = 1'b1;
        tick(); tick();
        chk("full_access", acc_seen - n0, 1);
        chk("err_sticky", packet_err, 1'b1);
`else
        chk("err_tied_low", packet_err, 1'b0);
`endif

        chk("unexpected_access", unexpected, 0);
        chk("acc_queue_drained", exp_acc_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_scan_ctrl.md
Name: gpio_scan_ctrl

Overview:
- Serial-scan front end for the SRAM test path in GPIO mode.
- Shifts a 112-bit command packet in MSB-first from the gpio_in pin and decodes it into port-0/port-1 SRAM signals plus an SRAM select.
- Issues one SRAM access per global_csb strobe and captures read data.
- Reloads the data fields of the packet with read data so the packet shifts back out on gpio_out.

Parameters:
- SEL_W, 4, SRAM select field width.
- ADDR_W, 16, per-port address width.
- DATA_W, 32, per-port data width.
- WMASK_W, 4, per-port write-mask width.
- NUM_SRAMS, 16, width of one-hot select output (2**SEL_W).
- PKT_W, SEL_W+2*(ADDR_W+DATA_W+2+WMASK_W) = 112, derived; do not override.

Ports:
- gpio_clk  in  1  scan/SRAM clock, all logic on rising edge.
- gpio_resetn  in  1  synchronous active-low reset.
- gpio_in  in  1  serial data in.
- gpio_scan  in  1  shift enable.
- gpio_sram_load  in  1  load captured dout into packet data fields.
- global_csb  in  1  active-low access strobe.
- gpio_out  out  1  serial data out, equals pkt[PKT_W-1].
- sram_sel  out  NUM_SRAMS  one-hot decode of sel field, registered.
- sram_csb0, sram_web0  out  1 each  port-0 controls.
- sram_wmask0  out  WMASK_W  port-0 write mask.
- sram_addr0  out  ADDR_W  port-0 address.
- sram_din0  out  DATA_W  port-0 write data.
- sram_dout0  in  DATA_W  port-0 read data from selected macro.
- sram_csb1, sram_web1, sram_wmask1, sram_addr1, sram_din1, sram_dout1: same as port 0 for port 1.
- packet_err  out  1  sticky short-packet flag.

Behaviour:
- Packet layout MSB to LSB: sel, addr0, din0, csb0, web0, wmask0, addr1, din1, csb1, web1, wmask1.
- Reset (gpio_resetn=0 at an edge): pkt=0, state IDLE, bit count=0, sram_csb0/1=1, sram_web0/1=1, all other SRAM outputs 0, sram_sel=0, dout regs 0, packet_err=0. Reset mid-access aborts; the csb outputs are high in the next cycle.
- Shift: when gpio_scan=1, pkt <= {pkt[PKT_W-2:0], gpio_in}. bit_cnt increments and saturates at PKT_W.
- FSM states: IDLE, ARMED, ACCESS, HOLD.
- IDLE:
  - global_csb=1 sampled -> ARMED.
  - Fresh from reset, global_csb=0 is ignored until global_csb has been seen high.
- ARMED: global_csb=0 and gpio_scan=0 sampled -> ACCESS. In the same edge:
  - register sram_* outputs from pkt fields (sram_csbN = pkt.csbN).
  - decode sram_sel.
  - clear bit_cnt.
- ACCESS (exactly 1 cycle):
  - SRAM macros sample sram_* on the edge ending this cycle.
  - On that same edge, dout reg N <= sram_doutN when csbN=0 and webN=1; otherwise dout reg N holds.
  - Next state HOLD; sram_csb0/1 return to 1.
- HOLD: wait for global_csb=1 -> ARMED. Strobe held low for many cycles gives one access only.
- global_csb=0 while gpio_scan=1: ignored; no access, state unchanged.
- Load: gpio_sram_load=1 with gpio_scan=0 -> din0 field <= dout reg 0, din1 field <= dout reg 1. All other fields unchanged. bit_cnt cleared.
- Load and scan both high: shift wins, load ignored.
- Load during ACCESS uses dout reg values from before the capture edge.
- Latency: strobe sampled low at edge E; SRAM access at edge E+1; dout regs valid after E+1; earliest useful load at edge E+2; first read bit appears on gpio_out after load.
- sel value >= NUM_SRAMS cannot occur (2**SEL_W); sram_sel always one-hot during access.

Optional Feature:
- Macro: GPIO_SCAN_PKT_CHECK_EN.
- Defined:
  - Entering ACCESS with bit_cnt < PKT_W sets packet_err (sticky until reset).
  - The access is suppressed: sram_csb0/1 stay 1, FSM still passes through ACCESS to HOLD, dout regs unchanged.
- Undefined: packet_err tied 0, bit_cnt logic removed, every strobe issues an access.

Test Plan:
- Reset: hold gpio_resetn=0 for 2 cycles mid-shift -> gpio_out=0, sram_csb0/1=1, sram_web0/1=1, sram_sel=0, packet_err=0.
- Write: shift 112 bits with sel=3, addr0=1, din0=3, csb0=0, web0=0, wmask0=F, csb1=1; pulse global_csb low 1 cycle -> one cycle with sram_csb0=0, sram_web0=0, sram_addr0=1, sram_din0=3, sram_sel=16'h0008, sram_csb1=1.
- Read-back: shift read packet with addr0=1, web0=1, csb1=0, web1=1, addr1=2; strobe; model returns dout0=3, dout1=24; idle 1 cycle; load 1 cycle; scan 112 -> bits equal the packet with din0=3, din1=24, all other fields unchanged.
- Strobe held low 5 cycles -> exactly one cycle with sram_csb0=0. Strobe low while gpio_scan=1 -> no access.
- Load and scan high together -> shift only, din fields not replaced.
- GPIO_SCAN_PKT_CHECK_EN: shift 50 bits then strobe -> packet_err=1, sram_csb0/1 stay 1. Full 112-bit packet after that -> access occurs, packet_err stays 1.
